// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_ERR
    } mem_fsm_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam int         REG_W           = 5;

    function automatic logic is_load(input logic [1:0] result_src);
        return result_src == RESULT_SRC_LOAD;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: register ids, handshakes, stall/flush/forward controls.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] rs1_dc_i;
    logic [REG_W-1:0] rs2_dc_i;
    logic [REG_W-1:0] rs1_ex_i;
    logic [REG_W-1:0] rs2_ex_i;
    logic [REG_W-1:0] rd_ex_i;
    logic [REG_W-1:0] rd_mem_i;
    logic [REG_W-1:0] rd_wb_i;
    logic [1:0]       result_src_ex_i;
    logic             reg_write_mem_i;
    logic             reg_write_wb_i;
    logic             pc_src_ex_i;
    logic             mem_req_mem_i;
    logic             mem_ack_i;
    fwd_e             fwd_a_ex_o;
    fwd_e             fwd_b_ex_o;
    logic             stall_f_o;
    logic             stall_d_o;
    logic             stall_e_o;
    logic             stall_m_o;
    logic             flush_d_o;
    logic             flush_e_o;
    logic             flush_w_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output rs1_dc_i, rs2_dc_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i,
               result_src_ex_i, reg_write_mem_i, reg_write_wb_i, pc_src_ex_i,
               mem_req_mem_i, mem_ack_i,
        input  fwd_a_ex_o, fwd_b_ex_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o,
               flush_d_o, flush_e_o, flush_w_o, mem_timeout_o, stall_cnt_o
    );

    modport slave (
        input  rs1_dc_i, rs2_dc_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i,
               result_src_ex_i, reg_write_mem_i, reg_write_wb_i, pc_src_ex_i,
               mem_req_mem_i, mem_ack_i,
        output fwd_a_ex_o, fwd_b_ex_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o,
               flush_d_o, flush_e_o, flush_w_o, mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand bypass select for one execute-stage source register; the younger MEM result wins over WB.
module hazard_ctrl_forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             reg_write_mem,
    input  logic             reg_write_wb,
    output fwd_e             fwd_sel
);
    always_comb begin
        fwd_sel = FWD_NONE;
        if (rs_ex != '0 && reg_write_mem && rd_mem == rs_ex) begin
            fwd_sel = FWD_MEM;
        end else if (rs_ex != '0 && reg_write_wb && rd_wb == rs_ex) begin
            fwd_sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use bubble, redirect flush, data-memory wait FSM with timeout,
// and a saturating count of fetch-stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    mem_fsm_e         state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [REG_W-1:0] rs_ex [2];
    fwd_e             fwd_sel [2];

    assign rs_ex[0] = bus.rs1_ex_i;
    assign rs_ex[1] = bus.rs2_ex_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_ctrl_forward_unit u_fwd (
                .rs_ex         (rs_ex[gi]),
                .rd_mem        (bus.rd_mem_i),
                .rd_wb         (bus.rd_wb_i),
                .reg_write_mem (bus.reg_write_mem_i),
                .reg_write_wb  (bus.reg_write_wb_i),
                .fwd_sel       (fwd_sel[gi])
            );
        end
    endgenerate

    assign bus.fwd_a_ex_o = fwd_sel[0];
    assign bus.fwd_b_ex_o = fwd_sel[1];

    logic mem_stall;
    logic load_use;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

    // A zero-cycle access (ack on the request cycle in IDLE) never stalls.
    assign mem_stall = (state_reg == MEM_IDLE && bus.mem_req_mem_i && !bus.mem_ack_i)
                     || (state_reg != MEM_IDLE);
    assign load_use  = is_load(bus.result_src_ex_i) && bus.rd_ex_i != '0
                     && (bus.rd_ex_i == bus.rs1_dc_i || bus.rd_ex_i == bus.rs2_dc_i);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            // E stays frozen, so a pending redirect is simply re-seen after release.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (bus.pc_src_ex_i) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign bus.stall_f_o     = stall_f;
    assign bus.stall_d_o     = stall_d;
    assign bus.stall_e_o     = stall_e;
    assign bus.stall_m_o     = stall_m;
    assign bus.flush_d_o     = flush_d;
    assign bus.flush_e_o     = flush_e;
    assign bus.flush_w_o     = flush_w;
    assign bus.mem_timeout_o = timeout_reg;
    assign bus.stall_cnt_o   = stall_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= MEM_IDLE;
            wait_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            case (state_reg)
                MEM_IDLE: begin
                    if (bus.mem_req_mem_i && !bus.mem_ack_i) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack_i) begin
                        state_reg    <= MEM_IDLE;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)) begin
                        state_reg   <= MEM_ERR;
                        timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                MEM_ERR: begin
                    state_reg <= MEM_ERR;
                end
                default: begin
                    state_reg <= MEM_IDLE;
                end
            endcase
            if (stall_f && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end
endmodule
